// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at accept, parked in pending registers and committed when the busy counter expires.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDUCtrl,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        MDUResultSel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUResult
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6
    } mdu_op_e;

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic [CW-1:0] count;
    logic [31:0]   pend_hi, pend_lo;
    logic          pend_wr;

    logic [63:0]   prod_s, prod_u;
    logic          a_neg, b_neg, div_ovf;
    logic [31:0]   a_abs, b_abs, div_n, div_d, uq, ur;
    logic [31:0]   next_hi, next_lo;
    logic          next_wr;
    logic [CW-1:0] next_cnt;

    assign busy      = (count != '0);
    assign MDUResult = MDUResultSel ? HI : LO;

    // Sign-extending to 64 bits lets one unsigned multiplier produce the signed product.
    assign prod_s = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
    assign prod_u = {32'b0, srcA} * {32'b0, srcB};

    // Signed divide runs on magnitudes through the shared unsigned divider; signs are restored afterwards.
    assign a_neg   = srcA[31];
    assign b_neg   = srcB[31];
    assign a_abs   = a_neg ? (~srcA + 32'd1) : srcA;
    assign b_abs   = b_neg ? (~srcB + 32'd1) : srcB;
    assign div_n   = (MDUCtrl == OP_DIV) ? a_abs : srcA;
    assign div_d   = (MDUCtrl == OP_DIV) ? b_abs : srcB;
    assign uq      = (div_d == 32'd0) ? 32'd0 : div_n / div_d;
    assign ur      = (div_d == 32'd0) ? 32'd0 : div_n % div_d;
    assign div_ovf = (srcA == 32'h8000_0000) && (srcB == 32'hFFFF_FFFF);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_hi  = '0;
        next_lo  = '0;
        next_wr  = 1'b0;
        next_cnt = '0;
        case (MDUCtrl)
            OP_MULT: begin
                {next_hi, next_lo} = prod_s;
                next_wr  = 1'b1;
                next_cnt = CW'(MULT_CYCLES);
            end
            OP_MULTU: begin
                {next_hi, next_lo} = prod_u;
                next_wr  = 1'b1;
                next_cnt = CW'(MULT_CYCLES);
            end
            OP_DIV: begin
                next_wr  = (srcB != 32'd0);
                next_cnt = CW'(DIV_CYCLES);
                if (div_ovf) begin
                    next_lo = 32'h8000_0000;
                    next_hi = 32'd0;
                end else begin
                    next_lo = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
                    next_hi = a_neg ? (~ur + 32'd1) : ur;
                end
            end
            OP_DIVU: begin
                next_wr  = (srcB != 32'd0);
                next_cnt = CW'(DIV_CYCLES);
                next_lo  = uq;
                next_hi  = ur;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else if (busy) begin
            count <= count - 1'b1;
            if (count == CW'(1) && pend_wr) begin
                HI <= pend_hi;
                LO <= pend_lo;
            end
        end else if (start) begin
            case (MDUCtrl)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                    count   <= next_cnt;
                    pend_hi <= next_hi;
                    pend_lo <= next_lo;
                    pend_wr <= next_wr;
                end
                OP_MTHI: HI <= srcA;
                OP_MTLO: LO <= srcA;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops against an arithmetic model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  MDUCtrl;
    logic [31:0] srcA, srcB;
    logic        MDUResultSel;
    logic        busy;
    logic [31:0] HI, LO, MDUResult;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .MDUCtrl(MDUCtrl),
        .srcA(srcA), .srcB(srcB), .MDUResultSel(MDUResultSel),
        .busy(busy), .HI(HI), .LO(LO), .MDUResult(MDUResult)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int op_cycles(input logic [3:0] op);
        if (op == 4'd1 || op == 4'd2) return 5;
        if (op == 4'd3 || op == 4'd4) return 10;
        return 0;
    endfunction

    // Reference: architectural effect of one accepted op, from plain 64-bit arithmetic.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            4'd1: begin q = sa * sb; exp_hi = q[63:32]; exp_lo = q[31:0]; end
            4'd2: begin p = ua * ub; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; exp_lo = q[31:0]; exp_hi = r[31:0]; end
            4'd4: if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
            4'd5: exp_hi = a;
            4'd6: exp_lo = a;
            default: ;
        endcase
    endtask

    task automatic check_regs(input string tag);
        n_cmp++;
        if (HI !== exp_hi || LO !== exp_lo) begin
            n_bad++;
            $display("FAIL %s: HI/LO got %h/%h expected %h/%h", tag, HI, LO, exp_hi, exp_lo);
        end
        MDUResultSel = 1'b1; #1;
        n_cmp++;
        if (MDUResult !== exp_hi) begin
            n_bad++;
            $display("FAIL %s mfhi: got %h expected %h", tag, MDUResult, exp_hi);
        end
        MDUResultSel = 1'b0; #1;
        n_cmp++;
        if (MDUResult !== exp_lo) begin
            n_bad++;
            $display("FAIL %s mflo: got %h expected %h", tag, MDUResult, exp_lo);
        end
    endtask

    // Issue one op, count busy cycles (scrambling operands and optionally poking start), then check.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit intrude);
        int n;
        logic [31:0] old_hi, old_lo;
        old_hi = exp_hi;
        old_lo = exp_lo;
        start = 1'b1; MDUCtrl = op; srcA = a; srcB = b;
        step();
        start = 1'b0;
        model(op, a, b);
        n = 0;
        while (busy && n < 100) begin
            n++;
            n_cmp++;
            if (HI !== old_hi || LO !== old_lo) begin
                n_bad++;
                $display("FAIL %s early write: HI/LO got %h/%h expected %h/%h", tag, HI, LO, old_hi, old_lo);
            end
            srcA = $urandom; srcB = $urandom;
            if (intrude) begin
                start = 1'b1;
                MDUCtrl = 4'($urandom_range(1, 6));
            end
            step();
            start = 1'b0;
        end
        n_cmp++;
        if (n != op_cycles(op)) begin
            n_bad++;
            $display("FAIL %s busy cycles: got %0d expected %0d", tag, n, op_cycles(op));
        end
        check_regs(tag);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; MDUCtrl = 4'd5; srcA = 32'hDEAD_BEEF; srcB = '0; MDUResultSel = 1'b0;
        step(); step();
        start = 1'b0; reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset busy: got %b expected 0", busy);
        end
        check_regs("reset");
    endtask

    task automatic test_mult();
        do_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        n_cmp++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
            n_bad++;
            $display("FAIL mult const: got %h/%h expected ffffffff/fffffffa", HI, LO);
        end
        do_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
        n_cmp++;
        if (HI !== 32'h0000_0002 || LO !== 32'hFFFF_FFFA) begin
            n_bad++;
            $display("FAIL multu const: got %h/%h expected 00000002/fffffffa", HI, LO);
        end
    endtask

    task automatic test_div();
        do_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        n_cmp++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
            n_bad++;
            $display("FAIL div const: got %h/%h expected ffffffff/fffffffd", HI, LO);
        end
        do_op("divu", 4'd4, 32'd7, 32'd2, 1'b0);
        do_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        n_cmp++;
        if (HI !== 32'd0 || LO !== 32'h8000_0000) begin
            n_bad++;
            $display("FAIL div_ovf const: got %h/%h expected 00000000/80000000", HI, LO);
        end
    endtask

    task automatic test_move();
        do_op("mthi", 4'd5, 32'h1234_5678, 32'd0, 1'b0);
        do_op("mtlo", 4'd6, 32'h9ABC_DEF0, 32'd0, 1'b0);
        do_op("none", 4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        do_op("ctrl9", 4'd9, 32'hFFFF_FFFF, 32'd1, 1'b0);
    endtask

    task automatic test_div_zero_and_ignore();
        do_op("set_hi55", 4'd5, 32'h55, 32'd0, 1'b0);
        do_op("set_lo55", 4'd6, 32'h55, 32'd0, 1'b0);
        do_op("div0", 4'd3, 32'd1234, 32'd0, 1'b0);
        do_op("divu0", 4'd4, 32'd99, 32'd0, 1'b1);
        do_op("mult_intrude", 4'd1, 32'h0001_0003, 32'hFFFF_0007, 1'b1);
        do_op("div_intrude", 4'd3, 32'h8765_4321, 32'h0000_0123, 1'b1);
    endtask

    task automatic test_reset_mid_op();
        start = 1'b1; MDUCtrl = 4'd1; srcA = 32'd1000; srcB = 32'd1000;
        step();
        start = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid busy: got %b expected 0", busy);
        end
        check_regs("reset_mid");
        do_op("after_reset", 4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
                default: ;
            endcase
            do_op($sformatf("rand%0d", i), op, a, b, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_move();
        test_div_zero_and_ignore();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
